multicycle_main_control: RTL and testbench
==========================================

// Module: multicycle_main_control
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath; issues the 2-bit alu_op consumed by the ALU control unit.
//  Sequences fetch/decode/execute/memory/writeback per opcode and drives all datapath enables/muxes.
//  Stalls on a memory ready handshake; flags unsupported opcodes. Sits between instruction register and datapath.
// PARAMETERS
//  SUPPORT_ADDI   1  1: opcode 001000 executes ADDI; 0: treated as illegal
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk            in   1  single clock, all state on rising edge
//  rst_n          in   1  asynchronous, active-low reset
//  opcode         in   6  instr[31:26] from instruction register, sampled in DECODE
//  mem_ready      in   1  memory completed current read/write this cycle
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load if ALU zero (branch)
//  ior_d          out  1  0: memory address = PC, 1: = ALUOut
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write request
//  ir_write       out  1  load instruction register
//  mem_to_reg     out  1  0: write ALUOut, 1: write MDR
//  reg_dst        out  1  0: rt, 1: rd
//  reg_write      out  1  register file write enable
//  alu_src_a      out  1  0: PC, 1: register A
//  alu_src_b      out  2  00: B, 01: const 4, 10: sign-ext imm, 11: sign-ext imm<<2
//  alu_op         out  2  00: add, 01: subtract, 10: use funct
//  pc_source      out  2  00: ALU result, 01: ALUOut, 10: jump target
//  illegal_op     out  1  one-cycle pulse: unsupported opcode decoded
// BEHAVIOUR
//  - Moore FSM, state register on clk/rst_n; outputs decoded from state (only ir_write/pc_write in FETCH gated by mem_ready).
//  - Reset (incl. mid-instruction): state -> IDLE immediately; every output 0 while rst_n=0 and in IDLE.
//  - Outputs not listed for a state are 0. Unreachable encodings -> IDLE next cycle.
//  IDLE:      all 0; -> FETCH.
//  FETCH:     mem_read=1, alu_src_b=01, alu_op=00, ir_write=pc_write=mem_ready; -> DECODE when mem_ready else hold.
//  DECODE:    alu_src_b=11, alu_op=00 (branch target precompute). Next by opcode:
//             000000 -> EXECUTE; 100011/101011 -> MEM_ADDR; 000100 -> BRANCH; 000010 -> JUMP;
//             001000 -> ADDI_EXEC (if SUPPORT_ADDI); any other -> ILLEGAL.
//  MEM_ADDR:  alu_src_a=1, alu_src_b=10, alu_op=00; LW -> MEM_READ, SW -> MEM_WRITE (opcode still held by IR).
//  MEM_READ:  mem_read=1, ior_d=1; -> MEM_WB on mem_ready else hold.
//  MEM_WB:    mem_to_reg=1, reg_write=1, reg_dst=0; -> FETCH.
//  MEM_WRITE: mem_write=1, ior_d=1, held stable across waits; -> FETCH on mem_ready.
//  EXECUTE:   alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB.  R_WB: reg_dst=1, reg_write=1; -> FETCH.
//  BRANCH:    alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; -> FETCH.
//  JUMP:      pc_write=1, pc_source=10; -> FETCH.
//  ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; -> ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0; -> FETCH.
//  ILLEGAL:   illegal_op=1, no write enables; -> FETCH (instruction discarded, PC already advanced).
//  - Cycles per instr (mem_ready=1): LW 5, SW 4, R/ADDI 4, BEQ 3, J 3; each mem_ready=0 cycle adds 1.
//  - reg_write, mem_write, pc_write never asserted in the same cycle.
// STRUCTURE
//  - mips_ctrl_pkg: state_t enum, opcode constants (OP_RTYPE/LW/SW/BEQ/J/ADDI),
//    alu_op constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), ctrl_word_t packed struct of outputs.
//  - Sub-module main_control_decode: combinational state_t -> ctrl_word_t; top holds state reg + next-state logic.
// TESTING
//  1. rst_n=0 mid-EXECUTE -> all outputs 0 same cycle; release -> IDLE 1 cycle, then FETCH with mem_read=1.
//  2. opcode=000000, mem_ready=1 -> FETCH,DECODE,EXECUTE(alu_op=10),R_WB(reg_dst=1,reg_write=1): 4 cycles.
//  3. opcode=100011, mem_ready low 2 cycles in MEM_READ -> LW takes 7 cycles; reg_write+mem_to_reg only in MEM_WB.
//  4. opcode=101011, mem_ready=0 3 cycles -> mem_write=1,ior_d=1 stable 4 cycles, never with reg_write.
//  5. opcode=000100 -> BRANCH: alu_op=01, pc_write_cond=1, pc_source=01; opcode=000010 -> pc_write=1, pc_source=10.
//  6. opcode=111111 (and 001000 with SUPPORT_ADDI=0) -> illegal_op 1-cycle pulse, zero write enables, back to FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  // Control FSM states; encodings beyond S_ILLEGAL are unreachable and recover to S_IDLE.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // alu_op encodings consumed by the ALU control unit.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // All datapath controls driven by the FSM, in port order.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_word_t;

  // Safe idle value: no enables, all selects at their zero encoding.
  localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_control_decode.sv
// Combinational state -> control word decode for the multicycle main control FSM.
module main_control_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  // Moore decode of the current state; only the FETCH write enables follow mem_ready.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_IDLE: begin
        ctrl = CTRL_IDLE;
      end
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is being decoded.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b0;
      end
      S_ILLEGAL: begin
        // Flag only: the instruction is dropped, no state is updated.
        ctrl.illegal_op = 1'b1;
      end
      default: begin
        ctrl = CTRL_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS datapath: state register, next-state logic
// and a decode sub-module producing the datapath controls from the current state.
module multicycle_main_control
  import mips_ctrl_pkg::*;
#(
  parameter bit SUPPORT_ADDI  = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ior_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  state_t     state_r;
  state_t     next_s;
  ctrl_word_t ctrl_s;
  logic       mem_ready_eff_s;

  // Without a handshake the memory is assumed to complete in one cycle.
  assign mem_ready_eff_s = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next-state selection; the opcode is taken live from the instruction register.
  always_comb begin
    next_s = S_IDLE;
    case (state_r)
      S_IDLE: next_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready_eff_s) next_s = S_DECODE;
        else                 next_s = S_FETCH;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_s = S_EXECUTE;
          OP_LW, OP_SW: next_s = S_MEM_ADDR;
          OP_BEQ:       next_s = S_BRANCH;
          OP_J:         next_s = S_JUMP;
          OP_ADDI: begin
            if (SUPPORT_ADDI) next_s = S_ADDI_EXEC;
            else              next_s = S_ILLEGAL;
          end
          default:      next_s = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        // A changed opcode here means the IR was disturbed; flag it rather than guess.
        if (opcode == OP_LW)      next_s = S_MEM_READ;
        else if (opcode == OP_SW) next_s = S_MEM_WRITE;
        else                      next_s = S_ILLEGAL;
      end
      S_MEM_READ: begin
        if (mem_ready_eff_s) next_s = S_MEM_WB;
        else                 next_s = S_MEM_READ;
      end
      S_MEM_WRITE: begin
        if (mem_ready_eff_s) next_s = S_FETCH;
        else                 next_s = S_MEM_WRITE;
      end
      S_EXECUTE:   next_s = S_R_WB;
      S_ADDI_EXEC: next_s = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_ILLEGAL: next_s = S_FETCH;
      default:     next_s = S_IDLE;
    endcase
  end

  // State register; reset forces IDLE so every output drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= next_s;
  end

  main_control_decode u_decode (
    .state     (state_r),
    .mem_ready (mem_ready_eff_s),
    .ctrl      (ctrl_s)
  );

  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign ior_d         = ctrl_s.ior_d;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign ir_write      = ctrl_s.ir_write;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign reg_dst       = ctrl_s.reg_dst;
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign pc_source     = ctrl_s.pc_source;
  assign illegal_op    = ctrl_s.illegal_op;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed self-checking bench for multicycle_main_control with a scoreboard of
// expected control words. A second instance built without ADDI support runs in lockstep.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b1;

  logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  logic       pc_write2, pc_write_cond2, ior_d2, mem_read2, mem_write2, ir_write2;
  logic       mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, illegal_op2;
  logic [1:0] alu_src_b2, alu_op2, pc_source2;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_q1[$];
  logic [16:0] exp_q2[$];

  // Field order: pcw pcwc iord mr mw irw m2r rdst rw asa asb[2] aop[2] psrc[2] ill
  localparam logic [16:0] W_IDLE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_FETCH_W = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_DECODE  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_MEMADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_MEMWR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0};
  localparam logic [16:0] W_RWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_BRANCH  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0};
  localparam logic [16:0] W_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0};
  localparam logic [16:0] W_ADDIX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0};
  localparam logic [16:0] W_ILLEGAL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1};

  multicycle_main_control #(.SUPPORT_ADDI(1'b1), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ior_d(ior_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op)
  );

  multicycle_main_control #(.SUPPORT_ADDI(1'b0), .MEM_HANDSHAKE(1'b1)) dut_noaddi (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .ior_d(ior_d2),
    .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
    .mem_to_reg(mem_to_reg2), .reg_dst(reg_dst2), .reg_write(reg_write2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
    .pc_source(pc_source2), .illegal_op(illegal_op2)
  );

  always #5 clk = ~clk;

  // Pop the expected words for this point and compare both instances, plus the
  // write-enable exclusivity rule on each.
  task automatic check_now(input string tag);
    logic [16:0] obs1, obs2, e1, e2;
    obs1 = {pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write, mem_to_reg,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
    obs2 = {pc_write2, pc_write_cond2, ior_d2, mem_read2, mem_write2, ir_write2, mem_to_reg2,
            reg_dst2, reg_write2, alu_src_a2, alu_src_b2, alu_op2, pc_source2, illegal_op2};
    e1 = exp_q1.pop_front();
    e2 = exp_q2.pop_front();
    checks++;
    assert (obs1 === e1) else begin
      failures++;
      $error("FAIL %s ctrl observed=%h expected=%h", tag, obs1, e1);
    end
    checks++;
    assert (obs2 === e2) else begin
      failures++;
      $error("FAIL %s noaddi_ctrl observed=%h expected=%h", tag, obs2, e2);
    end
    checks++;
    assert ($countones({reg_write, mem_write, pc_write}) <= 1) else begin
      failures++;
      $error("FAIL %s write_excl observed=%b expected=at_most_one", tag,
             {reg_write, mem_write, pc_write});
    end
  endtask

  // Drive one cycle of inputs, record expectations, check, then advance to the next negedge.
  task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                     input logic [16:0] e1, input logic [16:0] e2);
    opcode = op;
    mem_ready = rdy;
    exp_q1.push_back(e1);
    exp_q2.push_back(e2);
    #1;
    check_now(tag);
    @(negedge clk);
  endtask

  initial begin
    // Reset asserted from time zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_q1.push_back(W_IDLE);
    exp_q2.push_back(W_IDLE);
    #1;
    check_now("reset_held");
    @(negedge clk);
    rst_n = 1'b1;

    cyc("idle",       6'b000000, 1'b1, W_IDLE,    W_IDLE);
    // Fetch stalled one cycle, then R-type.
    cyc("fetch_wait", 6'b000000, 1'b0, W_FETCH_W, W_FETCH_W);
    cyc("r_fetch",    6'b000000, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("r_decode",   6'b000000, 1'b1, W_DECODE,  W_DECODE);
    cyc("r_exec",     6'b000000, 1'b1, W_EXEC,    W_EXEC);
    cyc("r_wb",       6'b000000, 1'b1, W_RWB,     W_RWB);
    // LW with two wait cycles in MEM_READ: 7 cycles.
    cyc("lw_fetch",   6'b100011, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("lw_decode",  6'b100011, 1'b1, W_DECODE,  W_DECODE);
    cyc("lw_addr",    6'b100011, 1'b1, W_MEMADDR, W_MEMADDR);
    cyc("lw_rd_w0",   6'b100011, 1'b0, W_MEMRD,   W_MEMRD);
    cyc("lw_rd_w1",   6'b100011, 1'b0, W_MEMRD,   W_MEMRD);
    cyc("lw_rd",      6'b100011, 1'b1, W_MEMRD,   W_MEMRD);
    cyc("lw_wb",      6'b100011, 1'b1, W_MEMWB,   W_MEMWB);
    // SW with three wait cycles: mem_write held for 4 cycles.
    cyc("sw_fetch",   6'b101011, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("sw_decode",  6'b101011, 1'b1, W_DECODE,  W_DECODE);
    cyc("sw_addr",    6'b101011, 1'b1, W_MEMADDR, W_MEMADDR);
    cyc("sw_wr_w0",   6'b101011, 1'b0, W_MEMWR,   W_MEMWR);
    cyc("sw_wr_w1",   6'b101011, 1'b0, W_MEMWR,   W_MEMWR);
    cyc("sw_wr_w2",   6'b101011, 1'b0, W_MEMWR,   W_MEMWR);
    cyc("sw_wr",      6'b101011, 1'b1, W_MEMWR,   W_MEMWR);
    // BEQ then J, 3 cycles each.
    cyc("beq_fetch",  6'b000100, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("beq_decode", 6'b000100, 1'b1, W_DECODE,  W_DECODE);
    cyc("beq_branch", 6'b000100, 1'b1, W_BRANCH,  W_BRANCH);
    cyc("j_fetch",    6'b000010, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("j_decode",   6'b000010, 1'b1, W_DECODE,  W_DECODE);
    cyc("j_jump",     6'b000010, 1'b1, W_JUMP,    W_JUMP);
    // Unsupported opcode: single illegal_op pulse, then back to FETCH.
    cyc("ill_fetch",  6'b111111, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("ill_decode", 6'b111111, 1'b1, W_DECODE,  W_DECODE);
    cyc("ill_pulse",  6'b111111, 1'b1, W_ILLEGAL, W_ILLEGAL);
    // ADDI: executes on the full instance, illegal on the instance without support.
    cyc("addi_fetch", 6'b001000, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("addi_dec",   6'b001000, 1'b1, W_DECODE,  W_DECODE);
    cyc("addi_exec",  6'b001000, 1'b1, W_ADDIX,   W_ILLEGAL);
    cyc("addi_wb",    6'b001000, 1'b1, W_ADDIWB,  W_FETCH_R);
    // Resynchronise both instances.
    rst_n = 1'b0;
    exp_q1.push_back(W_IDLE);
    exp_q2.push_back(W_IDLE);
    #1;
    check_now("reset_resync");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle2",      6'b000000, 1'b1, W_IDLE,    W_IDLE);
    cyc("r2_fetch",   6'b000000, 1'b1, W_FETCH_R, W_FETCH_R);
    cyc("r2_decode",  6'b000000, 1'b1, W_DECODE,  W_DECODE);
    // Reset in the middle of EXECUTE must clear outputs without waiting for a clock.
    opcode = 6'b000000;
    exp_q1.push_back(W_EXEC);
    exp_q2.push_back(W_EXEC);
    #1;
    check_now("r2_exec");
    #2;
    rst_n = 1'b0;
    exp_q1.push_back(W_IDLE);
    exp_q2.push_back(W_IDLE);
    #1;
    check_now("reset_mid_exec");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle3",      6'b000000, 1'b1, W_IDLE,    W_IDLE);
    cyc("fetch3",     6'b000000, 1'b1, W_FETCH_R, W_FETCH_R);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
